// File: rtl/centroid_mean_scheduler.sv
// rtl/centroid_mean_scheduler.sv - buffers group events and schedules one shared restoring divider
// Optional macro CENTROID_ROUND_EN: round-half-up dividend with saturating quotient.
module centroid_mean_scheduler #(
   parameter int DATA_W     = 40,
   parameter int SIZE_W     = 10,
   parameter int FIFO_DEPTH = 4,
   parameter int MIN_GROUP  = 3
) (
   input  logic              clk_200MHz_i,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] centroid_data_in,
   input  logic [SIZE_W-1:0] group_size_in,
   input  logic              centroid_strobe_in,
   output logic [DATA_W-1:0] result_data_out,
   output logic [SIZE_W-1:0] result_size_out,
   output logic              result_valid_out,
   input  logic              result_ready_in,
   output logic              busy_out,
   output logic              overflow_out
);
`ifdef CENTROID_ROUND_EN
   localparam int N = DATA_W + 1;
`else
   localparam int N = DATA_W;
`endif
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(N);
   localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [SIZE_W-1:0] MIN_SIZE = SIZE_W'(MIN_GROUP);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIVIDE, S_HOLD} state_t;
   state_t state;

   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
   logic [SIZE_W-1:0] fifo_size [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    fifo_count;

   logic [DATA_W-1:0] op_data;
   logic [SIZE_W-1:0] op_size;
   logic [SIZE_W-1:0] rem;
   logic [N-1:0]      shreg;
   logic [SIZE_W-1:0] divisor;
   logic [CNT_W-1:0]  bit_cnt;

   logic              fifo_empty;
   logic              fifo_full;
   logic              size_ok;
   logic              handshake;
   logic              pop;
   logic              push;
   logic              drop;
   logic [SIZE_W:0]   rem_shift;
   logic              rem_ge;
   logic [SIZE_W-1:0] rem_next;
   logic [N-1:0]      quot_next;
   logic [DATA_W-1:0] quot_final;
   logic [N-1:0]      dividend;

   assign fifo_empty = (fifo_count == '0);
   assign fifo_full  = (fifo_count == FULL_CNT);
   assign size_ok    = (group_size_in >= MIN_SIZE);
   assign handshake  = (state == S_HOLD) && result_valid_out && result_ready_in;
   // A pop in the same cycle frees a slot, so a full FIFO can still take this strobe.
   assign pop        = !fifo_empty && ((state == S_IDLE) || handshake);
   assign push       = centroid_strobe_in && size_ok && (!fifo_full || pop);
   assign drop       = centroid_strobe_in && size_ok && fifo_full && !pop;
   assign busy_out   = (state != S_IDLE) || !fifo_empty;

   assign rem_shift  = {rem, shreg[N-1]};
   assign rem_ge     = (rem_shift >= {1'b0, divisor});
   assign rem_next   = rem_ge ? SIZE_W'(rem_shift - {1'b0, divisor}) : rem_shift[SIZE_W-1:0];
   assign quot_next  = {shreg[N-2:0], rem_ge};

`ifdef CENTROID_ROUND_EN
   assign dividend   = {1'b0, op_data} + N'(op_size >> 1);
   assign quot_final = quot_next[N-1] ? '1 : quot_next[DATA_W-1:0];
`else
   assign dividend   = op_data;
   assign quot_final = quot_next;
`endif

   always_ff @(posedge clk_200MHz_i) begin
      if (push) begin
         fifo_data[wr_ptr] <= centroid_data_in;
         fifo_size[wr_ptr] <= group_size_in;
      end
   end

   always_ff @(posedge clk_200MHz_i or negedge reset_n) begin
      if (!reset_n) begin
         state            <= S_IDLE;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         fifo_count       <= '0;
         op_data          <= '0;
         op_size          <= '0;
         rem              <= '0;
         shreg            <= '0;
         divisor          <= '0;
         bit_cnt          <= '0;
         result_data_out  <= '0;
         result_size_out  <= '0;
         result_valid_out <= 1'b0;
         overflow_out     <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr  <= rd_ptr + 1'b1;
            op_data <= fifo_data[rd_ptr];
            op_size <= fifo_size[rd_ptr];
         end
         if (push && !pop)      fifo_count <= fifo_count + 1'b1;
         else if (pop && !push) fifo_count <= fifo_count - 1'b1;
         if (drop) overflow_out <= 1'b1;

         case (state)
            S_IDLE: begin
               if (pop) state <= S_LOAD;
            end
            S_LOAD: begin
               rem     <= '0;
               shreg   <= dividend;
               divisor <= op_size;
               bit_cnt <= LAST_BIT;
               state   <= S_DIVIDE;
            end
            S_DIVIDE: begin
               rem   <= rem_next;
               shreg <= quot_next;
               if (bit_cnt == '0) begin
                  result_data_out  <= quot_final;
                  result_size_out  <= divisor;
                  result_valid_out <= 1'b1;
                  state            <= S_HOLD;
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            S_HOLD: begin
               // Chain straight into the next division when work is queued.
               if (handshake) begin
                  result_valid_out <= 1'b0;
                  state            <= pop ? S_LOAD : S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_centroid_mean_scheduler.sv
// tb/tb_centroid_mean_scheduler.sv - directed bench with a queue-based mean model
`timescale 1ns/100ps
module tb_centroid_mean_scheduler;
   localparam int DATA_W = 40;
   localparam int SIZE_W = 10;
`ifdef CENTROID_ROUND_EN
   localparam int NSTEP   = DATA_W + 1;
   localparam int ROUND_Q = 3;
`else
   localparam int NSTEP   = DATA_W;
   localparam int ROUND_Q = 2;
`endif
   localparam int LAT = NSTEP + 3;
   localparam int GAP = NSTEP + 2;

   logic              clk_200MHz_i = 1'b0;
   logic              reset_n = 1'b1;
   logic [DATA_W-1:0] centroid_data_in = '0;
   logic [SIZE_W-1:0] group_size_in = '0;
   logic              centroid_strobe_in = 1'b0;
   logic [DATA_W-1:0] result_data_out;
   logic [SIZE_W-1:0] result_size_out;
   logic              result_valid_out;
   logic              result_ready_in = 1'b0;
   logic              busy_out;
   logic              overflow_out;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic [SIZE_W-1:0] size;
   } exp_t;
   exp_t exp_q[$];
   exp_t sb_e;

   int n_cmp = 0;
   int n_fail = 0;

   centroid_mean_scheduler dut (
      .clk_200MHz_i      (clk_200MHz_i),
      .reset_n           (reset_n),
      .centroid_data_in  (centroid_data_in),
      .group_size_in     (group_size_in),
      .centroid_strobe_in(centroid_strobe_in),
      .result_data_out   (result_data_out),
      .result_size_out   (result_size_out),
      .result_valid_out  (result_valid_out),
      .result_ready_in   (result_ready_in),
      .busy_out          (busy_out),
      .overflow_out      (overflow_out)
   );

   always #2.5 clk_200MHz_i = ~clk_200MHz_i;

   function automatic logic [DATA_W-1:0] model_mean(longint unsigned s, longint unsigned z);
      longint unsigned q;
`ifdef CENTROID_ROUND_EN
      q = (s + z / 2) / z;
      if (q > 64'h00FF_FFFF_FFFF) q = 64'h00FF_FFFF_FFFF;
`else
      q = s / z;
`endif
      return q[DATA_W-1:0];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk_200MHz_i);
      #1;
   endtask

   task automatic expect_event(input longint unsigned s, input longint unsigned z);
      exp_t e;
      e.data = model_mean(s, z);
      e.size = z[SIZE_W-1:0];
      exp_q.push_back(e);
   endtask

   task automatic pulse(input logic [DATA_W-1:0] s, input logic [SIZE_W-1:0] z);
      centroid_data_in   = s;
      group_size_in      = z;
      centroid_strobe_in = 1'b1;
      tick();
      centroid_strobe_in = 1'b0;
   endtask

   task automatic timed_pulse(input logic [DATA_W-1:0] s, input logic [SIZE_W-1:0] z, output int lat);
      centroid_data_in   = s;
      group_size_in      = z;
      centroid_strobe_in = 1'b1;
      lat = 0;
      do begin
         tick();
         centroid_strobe_in = 1'b0;
         lat++;
      end while (!result_valid_out && lat < 200);
   endtask

   task automatic wait_valid(input string name, output int n);
      n = 0;
      while (!result_valid_out && n < 300) begin
         tick();
         n++;
      end
      if (!result_valid_out) fail_now(name, 0, 1);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy_out && n < 600) begin
         tick();
         n++;
      end
      check(name, busy_out, 0);
   endtask

   task automatic do_reset(input string name);
      reset_n = 1'b0;
      #1;
      check({name, "_valid"}, result_valid_out, 0);
      check({name, "_data"}, result_data_out, 0);
      check({name, "_size"}, result_size_out, 0);
      check({name, "_busy"}, busy_out, 0);
      check({name, "_ovf"}, overflow_out, 0);
      exp_q.delete();
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
   endtask

   // Scoreboard: every handshake must match the model queue; held results must stay put.
   logic              p_valid = 1'b0;
   logic              p_ready = 1'b0;
   logic [DATA_W-1:0] p_data = '0;
   logic [SIZE_W-1:0] p_size = '0;
   always @(negedge clk_200MHz_i) begin
      if (!reset_n) begin
         p_valid <= 1'b0;
      end else begin
         if (p_valid && !p_ready) begin
            check("sb_hold_valid", result_valid_out, 1);
            if (result_valid_out) begin
               check("sb_hold_data", result_data_out, p_data);
               check("sb_hold_size", result_size_out, p_size);
            end
         end
         if (result_valid_out && result_ready_in) begin
            if (exp_q.size() == 0) begin
               fail_now("sb_unexpected", result_data_out, 0);
            end else begin
               sb_e = exp_q.pop_front();
               check("sb_data", result_data_out, sb_e.data);
               check("sb_size", result_size_out, sb_e.size);
            end
         end
         p_valid <= result_valid_out;
         p_ready <= result_ready_in;
         p_data  <= result_data_out;
         p_size  <= result_size_out;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got 0, required 1");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int n;
      tick();
      do_reset("reset");

      // Basic mean and latency
      result_ready_in = 1'b1;
      expect_event(12000, 4);
      timed_pulse(40'd12000, 10'd4, lat);
      check("basic_latency", lat, LAT);
      check("basic_data", result_data_out, 3000);
      check("basic_size", result_size_out, 4);
      tick();
      check("basic_valid_drop", result_valid_out, 0);
      wait_idle("basic_idle");

      // Undersized groups are ignored entirely
      pulse(40'd500, 10'd2);
      for (int i = 0; i < 4; i++) begin
         check("filter2_busy", busy_out, 0);
         check("filter2_valid", result_valid_out, 0);
         tick();
      end
      pulse(40'd777, 10'd0);
      for (int i = 0; i < 4; i++) begin
         check("filter0_busy", busy_out, 0);
         check("filter0_valid", result_valid_out, 0);
         tick();
      end
      check("filter_ovf", overflow_out, 0);

      // Rounding behaviour
      expect_event(10, 4);
      timed_pulse(40'd10, 10'd4, lat);
      check("round_latency", lat, LAT);
      check("round_data", result_data_out, ROUND_Q);
      wait_idle("round_idle");

      // Backpressure: five retained, sixth dropped
      result_ready_in = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         if (k <= 5) expect_event(3 * k, 3);
         pulse(DATA_W'(3 * k), 10'd3);
         tick();
      end
      check("bp_overflow", overflow_out, 1);
      check("bp_busy", busy_out, 1);
      wait_valid("bp_first_timeout", n);
      check("bp_first_data", result_data_out, 1);
      repeat (5) tick();
      check("bp_held_data", result_data_out, 1);
      result_ready_in = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         wait_valid("bp_timeout", n);
         check("bp_order", result_data_out, k);
         if (k > 1) check("bp_gap", n + 1, GAP);
         tick();
      end
      wait_idle("bp_idle");
      check("bp_ovf_sticky", overflow_out, 1);
      check("bp_drained", exp_q.size(), 0);

      // Full FIFO with a pop in the strobe cycle
      do_reset("reset2");
      result_ready_in = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         expect_event(30 * k, 3);
         pulse(DATA_W'(30 * k), 10'd3);
         tick();
      end
      wait_valid("simul_timeout", n);
      check("simul_pre_ovf", overflow_out, 0);
      result_ready_in = 1'b1;
      expect_event(180, 3);
      pulse(40'd180, 10'd3);
      check("simul_ovf", overflow_out, 0);
      wait_idle("simul_idle");
      check("simul_drained", exp_q.size(), 0);
      check("simul_ovf_end", overflow_out, 0);

      // Reset in the middle of a division
      pulse(40'd777, 10'd3);
      repeat (22) tick();
      check("mid_busy", busy_out, 1);
      do_reset("mid_reset");
      expect_event(999, 3);
      timed_pulse(40'd999, 10'd3, lat);
      check("post_reset_latency", lat, LAT);
      check("post_reset_data", result_data_out, 333);
      check("post_reset_size", result_size_out, 3);
      wait_idle("post_reset_idle");
      check("final_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/centroid_mean_scheduler.md
Name: centroid_mean_scheduler

Overview:
- Sits downstream of the centroid grouping stage on clk_200MHz_i.
- Captures each completed group event (accumulated 40-bit sum plus group size) into a small FIFO.
- Sequences one shared multi-cycle restoring divider to compute the group mean.
- Presents each mean to the SPI/output side on a valid/ready handshake, so back-to-back group events are never lost while the divider is busy.

Parameters:
- DATA_W, 40: width of accumulated centroid sum and of the mean result.
- SIZE_W, 10: width of group size.
- FIFO_DEPTH, 4: pending-event buffer entries; power of two, at least 2.
- MIN_GROUP, 3: smallest group size accepted; smaller events are discarded.

Ports:
- clk_200MHz_i, input, 1: system clock, all logic on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- centroid_data_in, input, DATA_W: group sum, sampled when centroid_strobe_in=1.
- group_size_in, input, SIZE_W: group size, sampled with the strobe.
- centroid_strobe_in, input, 1: one-cycle group-complete pulse.
- result_data_out, output, DATA_W: group mean (quotient).
- result_size_out, output, SIZE_W: group size associated with the current result.
- result_valid_out, output, 1: result available.
- result_ready_in, input, 1: consumer accepts the result.
- busy_out, output, 1: high whenever the FSM is not in IDLE or the FIFO is non-empty.
- overflow_out, output, 1: sticky flag, set when an event is dropped because the FIFO is full.

Behaviour:
- Reset (asynchronous assert, synchronous release): FSM=IDLE, FIFO empty, all outputs 0.
- Capture: on a strobe with group_size_in>=MIN_GROUP, the {data,size} pair is written to the FIFO. Events with smaller size, including size 0, are ignored and do not touch overflow_out.
- FIFO full: the event is dropped and overflow_out is set. overflow_out clears only on reset.
- Full FIFO with simultaneous pop: the pop frees a slot in the same cycle, so a strobe arriving in that cycle is accepted.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head and go to LOAD.
  - LOAD: initialise remainder=0, shift register=dividend, divisor=size, bit counter=N-1 (N=DATA_W, or DATA_W+1 with the optional feature). Go to DIVIDE.
  - DIVIDE: one restoring-division step per cycle. When the counter reaches 0, latch the quotient into result_data_out and the size into result_size_out, set result_valid_out, and go to HOLD.
  - HOLD: hold outputs stable while result_valid_out=1 and result_ready_in=0. When result_valid_out & result_ready_in, clear valid the next cycle. Then:
    - FIFO non-empty: pop and go directly to LOAD (no IDLE bubble).
    - FIFO empty: go to IDLE.
- Latency: strobe into an empty FIFO with the FSM idle gives valid exactly DATA_W+3 cycles later (write 1, pop/IDLE 1, LOAD 1, DIVIDE DATA_W). With default parameters this is 43 cycles.
- Arithmetic: unsigned floor division. Divisor is never 0 because of the MIN_GROUP filter. The quotient always fits in DATA_W bits.
- result_valid_out must never drop without a handshake.
- Buffering: at most one event in the divider/HOLD plus FIFO_DEPTH events queued.

Optional Feature:
- Macro: CENTROID_ROUND_EN.
- Defined:
  - The dividend becomes DATA_W+1 bits: sum + (size>>1), giving round-half-up.
  - DIVIDE runs DATA_W+1 steps, so latency is DATA_W+4.
  - A quotient >= 2^DATA_W saturates to all ones.
- Undefined: truncating division, latency as above, no extra adder in the logic.

Test Plan:
- Basic mean: strobe sum=12000, size=4, result_ready_in=1 -> result_valid_out high 43 cycles after the strobe with result_data_out=3000, result_size_out=4; valid drops the next cycle.
- Size filter: strobe sum=500, size=2, then size=0 -> no result_valid_out, busy_out stays 0, overflow_out stays 0.
- Backpressure/overflow: hold result_ready_in=0 and issue 6 strobes, sizes 3, sums 3,6,...,18, one per 2 cycles. Required response:
  - 5 events retained (1 in HOLD, 4 in FIFO), 6th dropped, overflow_out=1.
  - With ready released: results 1,2,3,4,5 in order, back-to-back divisions with no IDLE bubble.
- Rounding: sum=10, size=4 -> 2 without CENTROID_ROUND_EN; 3 with it, valid at 44 cycles.
- Full FIFO with simultaneous pop: with the FIFO full and HOLD handshaking, strobe in the handshake cycle -> the event is accepted and overflow_out stays 0.
- Reset mid-divide: assert reset_n=0 20 cycles into DIVIDE -> all outputs 0 immediately. After release, the next strobe (sum=999, size=3) gives 333 with normal latency.
